// File: rtl/block_idx_select.sv
// block_idx_select: streaming top-k selector. Keeps the k highest-scoring
// block indices in a table sorted by descending score, then launches the gather.
// Ports:
//   clk/rst                      clock, asynchronous active-high reset
//   start, k_sel                 begin a selection (IDLE/HOLD only), keep min(k_sel,KMAX)
//   in_valid/in_ready            score beat handshake, one insertion per cycle
//   in_score, in_idx, in_last    beat payload; in_last ends the stream
//   idx_rd_addr/idx_rd_data      combinational table read (entry 0 = highest score)
//   sel_count                    number of valid table entries
//   gather_start, busy, done     one-cycle launch pulse, ACCEPT|LAUNCH, HOLD
module block_idx_select #(
  parameter int KMAX    = 16,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        k_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [15:0]        in_idx,
  input  logic               in_last,
  input  logic [15:0]        idx_rd_addr,
  output logic [15:0]        idx_rd_data,
  output logic [15:0]        sel_count,
  output logic               gather_start,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_LAUNCH = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        k_eff_q, k_eff_d;
  logic [15:0]        sel_count_q, sel_count_d;
  logic [SCORE_W-1:0] score_q [KMAX];
  logic [SCORE_W-1:0] score_d [KMAX];
  logic [15:0]        idx_q   [KMAX];
  logic [15:0]        idx_d   [KMAX];

  logic [15:0]        k_sel_min;
  logic [15:0]        ins_pos;
  logic               start_ok;

  assign k_sel_min = (k_sel > 16'(KMAX)) ? 16'(KMAX) : k_sel;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_HOLD));

  // Valid entries are always packed at the front of the table, so the
  // insertion slot is simply how many of them score >= the new beat.
  // Using >= (not >) places a tied newcomer behind the earlier arrival.
  always_comb begin
    ins_pos = 16'd0;
    for (int i = 0; i < KMAX; i++) begin
      if ((16'(i) < sel_count_q) && (score_q[i] >= in_score)) begin
        ins_pos = ins_pos + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_eff_d     = k_eff_q;
    sel_count_d = sel_count_q;
    for (int i = 0; i < KMAX; i++) begin
      score_d[i] = score_q[i];
      idx_d[i]   = idx_q[i];
    end

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (start_ok) begin
          state_d     = S_ACCEPT;
          k_eff_d     = k_sel_min;
          sel_count_d = 16'd0;
          for (int i = 0; i < KMAX; i++) begin
            score_d[i] = '0;
            idx_d[i]   = 16'd0;
          end
        end
      end

      S_ACCEPT: begin
        if (in_valid) begin
          if (ins_pos < k_eff_q) begin
            // Shift the tail down one slot; whatever sat at k_eff-1 falls off.
            for (int i = 1; i < KMAX; i++) begin
              if ((16'(i) > ins_pos) && (16'(i) < k_eff_q)) begin
                score_d[i] = score_q[i-1];
                idx_d[i]   = idx_q[i-1];
              end
            end
            for (int i = 0; i < KMAX; i++) begin
              if (16'(i) == ins_pos) begin
                score_d[i] = in_score;
                idx_d[i]   = in_idx;
              end
            end
            if (sel_count_q < k_eff_q) begin
              sel_count_d = sel_count_q + 16'd1;
            end
          end
          if (in_last) begin
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        state_d = S_HOLD;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_eff_q     <= 16'd0;
      sel_count_q <= 16'd0;
      for (int i = 0; i < KMAX; i++) begin
        score_q[i] <= '0;
        idx_q[i]   <= 16'd0;
      end
    end else begin
      state_q     <= state_d;
      k_eff_q     <= k_eff_d;
      sel_count_q <= sel_count_d;
      for (int i = 0; i < KMAX; i++) begin
        score_q[i] <= score_d[i];
        idx_q[i]   <= idx_d[i];
      end
    end
  end

  // Read mux compares the full 16-bit address, so out-of-range addresses
  // (including those beyond KMAX) read as 0.
  always_comb begin
    idx_rd_data = 16'd0;
    for (int i = 0; i < KMAX; i++) begin
      if ((16'(i) == idx_rd_addr) && (idx_rd_addr < sel_count_q)) begin
        idx_rd_data = idx_q[i];
      end
    end
  end

  assign in_ready     = (state_q == S_ACCEPT);
  assign gather_start = (state_q == S_LAUNCH);
  assign busy         = (state_q == S_ACCEPT) || (state_q == S_LAUNCH);
  assign done         = (state_q == S_HOLD);
  assign sel_count    = sel_count_q;

endmodule

// File: tb/tb_block_idx_select.sv
// Directed bench for block_idx_select with KMAX=16, SCORE_W=16.
module tb_block_idx_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_score;
  logic [15:0] in_idx;
  logic        in_last;
  logic [15:0] idx_rd_addr;
  logic [15:0] idx_rd_data;
  logic [15:0] sel_count;
  logic        gather_start;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  block_idx_select #(.KMAX(16), .SCORE_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_sel        (k_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_score     (in_score),
    .in_idx       (in_idx),
    .in_last      (in_last),
    .idx_rd_addr  (idx_rd_addr),
    .idx_rd_data  (idx_rd_data),
    .sel_count    (sel_count),
    .gather_start (gather_start),
    .busy         (busy),
    .done         (done)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] k);
    start = 1'b1;
    k_sel = k;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] s, input logic [15:0] ix, input logic last);
    in_valid = 1'b1;
    in_score = s;
    in_idx   = ix;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    idx_rd_addr = a;
    #1;
    chk(tag, idx_rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_sel = 16'd0; in_valid = 1'b0;
    in_score = 16'd0; in_idx = 16'd0; in_last = 1'b0; idx_rd_addr = 16'd0;
    tick();
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_gather", {15'd0, gather_start}, 16'd0);
    chk("rst_sel_count", sel_count, 16'd0);
    rd("rst_rd0", 16'd0, 16'd0);
    rst = 1'b0;
    tick();

    // Test 1: k=4, mixed scores with a tie.
    do_start(16'd4);
    chk("t1_in_ready", {15'd0, in_ready}, 16'd1);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    beat(16'd5, 16'd10, 1'b0);
    beat(16'd9, 16'd11, 1'b0);
    beat(16'd1, 16'd12, 1'b0);
    beat(16'd7, 16'd13, 1'b0);
    beat(16'd9, 16'd14, 1'b0);
    beat(16'd3, 16'd15, 1'b1);
    chk("t1_gather_launch", {15'd0, gather_start}, 16'd1);
    chk("t1_in_ready_launch", {15'd0, in_ready}, 16'd0);
    chk("t1_busy_launch", {15'd0, busy}, 16'd1);
    chk("t1_sel_count_launch", sel_count, 16'd4);
    tick();
    chk("t1_gather_hold", {15'd0, gather_start}, 16'd0);
    chk("t1_done", {15'd0, done}, 16'd1);
    chk("t1_busy_hold", {15'd0, busy}, 16'd0);
    rd("t1_rd0", 16'd0, 16'd11);
    rd("t1_rd1", 16'd1, 16'd14);
    rd("t1_rd2", 16'd2, 16'd13);
    rd("t1_rd3", 16'd3, 16'd10);
    rd("t1_rd4", 16'd4, 16'd0);
    tick();

    // Test 2: k_sel above KMAX clamps to 16; ascending scores 1..20.
    do_start(16'd100);
    for (int s = 1; s <= 20; s++) begin
      chk("t2_in_ready", {15'd0, in_ready}, 16'd1);
      beat(16'(s), 16'(100 + s), (s == 20));
    end
    chk("t2_gather", {15'd0, gather_start}, 16'd1);
    tick();
    chk("t2_sel_count", sel_count, 16'd16);
    for (int i = 0; i < 16; i++) begin
      rd("t2_rd", 16'(i), 16'(120 - i));
    end
    rd("t2_rd16", 16'd16, 16'd0);
    tick();

    // Test 3: k_sel=0 drops everything but still launches.
    do_start(16'd0);
    beat(16'd8, 16'd1, 1'b0);
    chk("t3_in_ready", {15'd0, in_ready}, 16'd1);
    beat(16'd9, 16'd2, 1'b0);
    beat(16'd7, 16'd3, 1'b1);
    chk("t3_gather", {15'd0, gather_start}, 16'd1);
    chk("t3_sel_count", sel_count, 16'd0);
    tick();
    chk("t3_done", {15'd0, done}, 16'd1);
    rd("t3_rd0", 16'd0, 16'd0);

    // Test 4: reset after 2 of 5 beats, then a clean rerun.
    do_start(16'd4);
    beat(16'd5, 16'd10, 1'b0);
    beat(16'd9, 16'd11, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_busy", {15'd0, busy}, 16'd0);
    chk("t4_in_ready", {15'd0, in_ready}, 16'd0);
    chk("t4_sel_count", sel_count, 16'd0);
    chk("t4_gather", {15'd0, gather_start}, 16'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_no_gather", {15'd0, gather_start}, 16'd0);
      chk("t4_idle_done", {15'd0, done}, 16'd0);
    end
    do_start(16'd4);
    beat(16'd5, 16'd10, 1'b0);
    beat(16'd9, 16'd11, 1'b0);
    beat(16'd1, 16'd12, 1'b0);
    beat(16'd7, 16'd13, 1'b0);
    beat(16'd9, 16'd14, 1'b0);
    beat(16'd3, 16'd15, 1'b1);
    tick();
    chk("t4_sel_count_rerun", sel_count, 16'd4);
    rd("t4_rd0", 16'd0, 16'd11);
    rd("t4_rd1", 16'd1, 16'd14);
    rd("t4_rd3", 16'd3, 16'd10);
    tick();

    // Test 5: restart from HOLD, tie keeps arrival order.
    do_start(16'd2);
    chk("t5_cleared_count", sel_count, 16'd0);
    rd("t5_cleared_rd0", 16'd0, 16'd0);
    beat(16'd4, 16'd1, 1'b0);
    beat(16'd4, 16'd2, 1'b1);
    tick();
    chk("t5_sel_count", sel_count, 16'd2);
    rd("t5_rd0", 16'd0, 16'd1);
    rd("t5_rd1", 16'd1, 16'd2);
    tick();

    // Test 6: start during ACCEPT and in_valid during HOLD are ignored.
    do_start(16'd3);
    beat(16'd2, 16'd7, 1'b0);
    start = 1'b1;
    k_sel = 16'd1;
    tick();
    start = 1'b0;
    chk("t6_count_after_start", sel_count, 16'd1);
    chk("t6_in_ready", {15'd0, in_ready}, 16'd1);
    beat(16'd5, 16'd8, 1'b0);
    beat(16'd3, 16'd9, 1'b1);
    tick();
    chk("t6_sel_count", sel_count, 16'd3);
    in_valid = 1'b1;
    in_score = 16'd99;
    in_idx   = 16'd55;
    in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_hold_in_ready", {15'd0, in_ready}, 16'd0);
      chk("t6_hold_done", {15'd0, done}, 16'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t6_hold_count", sel_count, 16'd3);
    rd("t6_rd0", 16'd0, 16'd8);
    rd("t6_rd1", 16'd1, 16'd9);
    rd("t6_rd2", 16'd2, 16'd7);
    rd("t6_rd3", 16'd3, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_idx_select.md
# block_idx_select

Top-k block selector that feeds the block-gather stage. It accepts a stream of (score, block index) pairs over a valid/ready handshake and keeps the `k` highest-scoring block indices in a register array, sorted in descending score order. When the stream ends, it pulses `gather_start` and holds the sorted list. The gather stage then reads the list through a combinational index-read port, with `sel_count` driving the gather's `s_tokens`.

## Interface
- `KMAX`, default 16: capacity of the index table in entries (2..64).
- `SCORE_W`, default 16: width of the unsigned score.
- `clk`  in  1  Clock; all state is updated on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start`  in  1  Begins a new selection. Honoured in IDLE and HOLD only.
- `k_sel`  in  16  Number of indices to keep. Sampled when `start` is honoured.
- `in_valid`  in  1  Score beat valid.
- `in_ready`  out  1  Block can accept a score beat.
- `in_score`  in  SCORE_W  Block score, unsigned.
- `in_idx`  in  16  Block index associated with `in_score`.
- `in_last`  in  1  Marks the final beat of the stream.
- `idx_rd_addr`  in  16  Table read address, driven by the gather stage.
- `idx_rd_data`  out  16  Table read data, combinational from `idx_rd_addr`.
- `sel_count`  out  16  Number of valid table entries; feeds the gather's `s_tokens`.
- `gather_start`  out  1  One-cycle pulse that launches the gather.
- `busy`  out  1  High in ACCEPT and LAUNCH.
- `done`  out  1  High in HOLD (level).

## Operation
- States are IDLE, ACCEPT, LAUNCH and HOLD. Reset enters IDLE.
- IDLE --start--> ACCEPT; HOLD --start--> ACCEPT. `start` is ignored in ACCEPT and LAUNCH.
- On an honoured `start`:
  - Latch `k_eff = min(k_sel, KMAX)`.
  - Clear all table entries to score 0 / index 0 and mark them invalid.
  - Set `sel_count` to 0.
- ACCEPT:
  - `in_ready = 1`. A beat is accepted when `in_valid && in_ready`.
  - Insertion position: p = number of valid entries whose score is >= `in_score`. Ties therefore keep arrival order, with the earlier beat ranked higher.
  - If p < `k_eff`:
    - Entries p..`k_eff`-2 shift down by one, and the entry at `k_eff`-1 is discarded.
    - The beat is written at position p.
    - `sel_count` increments, saturating at `k_eff`.
  - If p >= `k_eff`, the beat is dropped and the table is unchanged.
  - Each insertion completes in one cycle, so back-to-back beats are accepted at one per cycle.
  - An accepted beat with `in_last = 1` moves the state to LAUNCH. That beat is inserted like any other.
- LAUNCH: `gather_start = 1` for exactly one cycle, then the state moves to HOLD.
- HOLD: the table and `sel_count` are frozen and `done = 1` until the next `start`.
- Read port:
  - `idx_rd_data` = index of entry `idx_rd_addr` when `idx_rd_addr < sel_count`; otherwise 0.
  - The read port is valid in every state but is meaningful from LAUNCH onward.
  - Entry 0 is the highest score.
- `k_sel = 0`:
  - All beats are accepted and dropped, and `sel_count` stays 0.
  - `gather_start` still pulses.
- Score comparison is unsigned, full `SCORE_W` width. There is no arithmetic on indices.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`, `gather_start`, `busy`, `done` = 0.
  - `sel_count` = 0.
  - `idx_rd_data` = 0, since no entries are valid.
- `start` honoured at edge t: `in_ready` and `busy` are 1 from cycle t+1.
- Last beat accepted at edge t:
  - Cycle t+1: LAUNCH, `gather_start = 1`, `in_ready = 0`, table already contains the last beat.
  - Cycle t+2: HOLD, `done = 1`, `busy = 0`.
- `in_ready` is 0 in IDLE, LAUNCH and HOLD. `in_valid` is ignored in those states and nothing is inserted.
- `rst` mid-stream: the state returns to IDLE immediately, the table is cleared, and no `gather_start` is issued. The upstream stage must restart its stream.
- `start` coincident with `rst`: reset wins.
- `in_last` on the first beat: a one-entry stream is legal.

## Test plan
- `k_sel=4`. Beats (score, idx) = (5,10) (9,11) (1,12) (7,13) (9,14) (3,15, last) -> `sel_count=4`, table reads 11, 14, 13, 10; address 4 reads 0; `gather_start` is high exactly one cycle after the last beat.
- `k_sel=100`, `KMAX=16`, 20 beats with scores 1..20 -> `sel_count=16`, table reads the indices of scores 20..5 in order; `in_ready` stays 1 every ACCEPT cycle.
- `k_sel=0`, 3 beats -> all accepted, `sel_count=0`, `gather_start` pulses, `done=1`, address 0 reads 0.
- `rst` asserted after 2 of 5 beats -> immediately `busy=0`, `in_ready=0`, `sel_count=0`, and no `gather_start`. A new `start` followed by a full stream then produces a correct table.
- In HOLD, assert `start` with `k_sel=2` and stream (4,1) (4,2, last) -> table cleared first, final table reads 1, 2 (tie keeps arrival order), `sel_count=2`.
- `start` pulsed during ACCEPT, and `in_valid` held high during HOLD -> both ignored, table and `sel_count` unchanged.
